pe_bus_decoder: RTL

Parametrised CPU-side address decoder and response multiplexer for the processing element. It sits between the RS5 data port and N memory-mapped targets: data memory, PLIC, RTC, DMNI config, and reserved regions. It generalises the fixed one-hot region decode to a configurable target count and adds per-target wait states via ready handshakes, a stall to the core, an access timeout, and error responses for unmapped accesses.

---
 rtl/pe_bus_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pe_bus_decoder.sv
// CPU-side region decoder / response mux with per-target wait states, access timeout and error responses.
// Optional error address/count capture is enabled by defining BUS_ERR_CAPTURE_EN.
module pe_bus_decoder #(
  parameter int                    N_TGT      = 5,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_LSB    = 24,
  parameter int                    TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic [3:0]                  we_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        rvalid_o,
  output logic                        stall_o,
  output logic                        err_o,
  output logic [N_TGT-1:0]            tgt_en_o,
  input  logic [N_TGT-1:0]            tgt_ready_i,
  input  logic [N_TGT*DATA_WIDTH-1:0] tgt_data_i,
  input  logic                        err_clr_i,
  output logic [ADDR_WIDTH-1:0]       err_addr_o,
  output logic [15:0]                 err_cnt_o
);
  localparam int UW = ADDR_WIDTH - SEL_LSB;
  localparam int SW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   s_q, s_d;
  logic            resp_q, resp_d;
  logic            resp_rd_q, resp_rd_d;
  logic            resp_err_q, resp_err_d;
  logic [UW-1:0]   u;
  logic [SW-1:0]   dec_sel;
  logic            dec_hit;
  logic            timeout_hit;
  logic            err_evt;
  logic [N_TGT-1:0] tgt_en;
  logic            stall;

  assign u = addr_i[ADDR_WIDTH-1:SEL_LSB];

  // Region 0 is the all-zero select field; region i>0 is the one-hot field with bit i-1 set.
  always_comb begin
    dec_sel = '0;
    dec_hit = (u == '0);
    for (int i = 1; i < N_TGT; i++) begin
      if (u == (UW'(1) << (i - 1))) begin
        dec_sel = SW'(i);
        dec_hit = 1'b1;
      end
    end
  end

  // The entry cycle in IDLE already stalls, so WAIT gives up after TIMEOUT-1 counted cycles.
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    s_d        = s_q;
    resp_d     = 1'b0;
    resp_err_d = 1'b0;
    resp_rd_d  = (we_i == 4'b0000);
    tgt_en     = '0;
    stall      = 1'b0;
    err_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          if (dec_hit) begin
            tgt_en[dec_sel] = 1'b1;
            s_d             = dec_sel;
            if (tgt_ready_i[dec_sel]) begin
              resp_d = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = WAIT;
              timer_d = '0;
            end
          end else begin
            resp_d     = 1'b1;
            resp_err_d = 1'b1;
            err_evt    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (tgt_ready_i[s_q]) begin
          tgt_en[s_q] = 1'b1;
          resp_d      = 1'b1;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          resp_d     = 1'b1;
          resp_err_d = 1'b1;
          err_evt    = 1'b1;
          state_d    = IDLE;
        end else begin
          tgt_en[s_q] = 1'b1;
          stall       = 1'b1;
          if (timer_q != '1) timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      s_q        <= '0;
      resp_q     <= 1'b0;
      resp_rd_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      s_q        <= s_d;
      resp_q     <= resp_d;
      resp_rd_q  <= resp_rd_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Select and stall are combinational from en_i, so reset must mask them explicitly.
  assign tgt_en_o = rst_ni ? tgt_en : '0;
  assign stall_o  = rst_ni & stall;
  assign rvalid_o = resp_q & resp_rd_q;
  assign err_o    = resp_q & resp_err_q;

  always_comb begin
    data_o = '0;
    if (resp_q && resp_rd_q)
      data_o = resp_err_q ? ERR_DATA : tgt_data_i[DATA_WIDTH*int'(s_q) +: DATA_WIDTH];
  end

`ifdef BUS_ERR_CAPTURE_EN
  logic                  held_q, held_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  // Clear is applied before the same-cycle error so that error counts as the first one.
  always_comb begin
    held_d     = held_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr_i) begin
      held_d     = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end
    if (err_evt) begin
      if (!held_d) begin
        held_d     = 1'b1;
        err_addr_d = addr_i;
      end
      if (err_cnt_d != 16'hFFFF) err_cnt_d = err_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q     <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      held_q     <= held_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`else
  logic unused_ok;
  assign unused_ok  = &{1'b0, err_clr_i, err_evt, addr_i};
  assign err_addr_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule
